// File: rtl/mux4_rr_arbiter.sv
// Purpose : round-robin arbiter sharing one SIZE-bit 4:1 mux between four requesters.
// Latency : 1 cycle from an unmasked req (output free) to out_valid/out_data; ack follows the capture edge.
// Backpr. : out_valid & !out_ready freezes every output register and the pointer; no ack is issued.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req[3:0], d0..d3  requests (held until ack) and their data words
//   ack[3:0]          one-cycle one-hot pulse: d_i was captured at the previous edge
//   sel, grant        index / one-hot of the most recent capture (grant=0 before the first one)
//   out_data          registered mux output
//   out_valid         out_data holds an unconsumed word
//   out_ready         consumer takes out_data when out_valid & out_ready
//   lock              only with MUX4_ARB_LOCK_EN: keep the last winner while it still requests
//
// Optional feature macro: MUX4_ARB_LOCK_EN
module mux4_rr_arbiter #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      req,
  input  logic [SIZE-1:0] d0,
  input  logic [SIZE-1:0] d1,
  input  logic [SIZE-1:0] d2,
  input  logic [SIZE-1:0] d3,
`ifdef MUX4_ARB_LOCK_EN
  input  logic            lock,
`endif
  output logic [3:0]      ack,
  output logic [1:0]      sel,
  output logic [3:0]      grant,
  output logic [SIZE-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [1:0]      ptr;
  logic            free;
  logic [3:0]      mreq;
  logic [1:0]      win;
  logic [1:0]      idx;
  logic            found;
  logic            advance;
  logic [SIZE-1:0] win_data;

  // Output register can take a new word if empty or being consumed this cycle.
  assign free = !out_valid | out_ready;

  // A requester sees its ack in the same cycle it may still be holding req;
  // masking it here stops the same word from being captured twice.
  assign mreq = req & ~ack;

  always_comb begin
    win     = ptr;
    found   = 1'b0;
    idx     = '0;
    advance = 1'b1;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && mreq[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
`ifdef MUX4_ARB_LOCK_EN
    // Lock looks at the raw req of the previous winner (its ack mask is ignored)
    // and leaves the pointer where it was so the rotation resumes afterwards.
    if (lock && (|grant) && req[sel]) begin
      win     = sel;
      found   = 1'b1;
      advance = 1'b0;
    end
`endif
  end

  always_comb begin
    win_data = d0;
    case (win)
      2'd0: win_data = d0;
      2'd1: win_data = d1;
      2'd2: win_data = d2;
      2'd3: win_data = d3;
      default: win_data = d0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sel       <= '0;
      grant     <= '0;
      ack       <= '0;
      ptr       <= '0;
    end else if (free) begin
      if (found) begin
        out_valid <= 1'b1;
        out_data  <= win_data;
        sel       <= win;
        grant     <= 4'b0001 << win;
        ack       <= 4'b0001 << win;
        ptr       <= advance ? win + 2'd1 : ptr;
      end else begin
        // Nothing to capture: either already empty or the held word is consumed now.
        out_valid <= 1'b0;
        ack       <= '0;
      end
    end else begin
      ack <= '0;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic [1:0]  sel;
    logic [3:0]  grant;
    logic [3:0]  ack;
    int          ptr;
  } model_t;

  logic             clk;
  logic             rst_n;
  logic [3:0]       req;
  logic [3:0][31:0] dv;
  logic             lock;
  logic [3:0]       ack;
  logic [1:0]       sel;
  logic [3:0]       grant;
  logic [31:0]      out_data;
  logic             out_valid;
  logic             out_ready;

  int n_cmp;
  int n_bad;

  model_t m;
  model_t m_nxt;

  mux4_rr_arbiter #(.SIZE(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .d0        (dv[0]),
    .d1        (dv[1]),
    .d2        (dv[2]),
    .d3        (dv[3]),
`ifdef MUX4_ARB_LOCK_EN
    .lock      (lock),
`endif
    .ack       (ack),
    .sel       (sel),
    .grant     (grant),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour: pick the first requester (not just acked) in circular
  // order from the pointer; lock (when present) keeps the last winner.
  function automatic model_t step(input model_t cur, input logic [3:0] rq,
                                  input logic [3:0][31:0] d, input logic rdy,
                                  input logic lk);
    model_t nx;
    int     w;
    bit     keep;
    nx     = cur;
    nx.ack = '0;
    w      = -1;
    keep   = 0;
    if (cur.valid && !rdy) return nx;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (cur.ptr + k) % 4;
      if (w < 0 && rq[i] && !cur.ack[i]) w = i;
    end
`ifdef MUX4_ARB_LOCK_EN
    if (lk && cur.grant != 0 && rq[cur.sel]) begin
      w    = int'(cur.sel);
      keep = 1;
    end
`else
    if (lk) keep = 0;
`endif
    if (w < 0) begin
      nx.valid = 1'b0;
      return nx;
    end
    nx.valid = 1'b1;
    nx.data  = d[w];
    nx.sel   = 2'(w);
    nx.grant = 4'(1 << w);
    nx.ack   = 4'(1 << w);
    nx.ptr   = keep ? cur.ptr : (w + 1) % 4;
    return nx;
  endfunction

  always_comb m_nxt = step(m, req, dv, out_ready, lock);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= m_nxt;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Advance one clock edge and compare every output against the model.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_n) begin
      n_cmp++;
      if ({out_valid, out_data, sel, grant, ack} !== {m.valid, m.data, m.sel, m.grant, m.ack}) begin
        n_bad++;
        $display("FAIL model t=%0t: got v=%0b d=%h s=%0d g=%b a=%b expected v=%0b d=%h s=%0d g=%b a=%b",
                 $time, out_valid, out_data, sel, grant, ack,
                 m.valid, m.data, m.sel, m.grant, m.ack);
      end
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    req       = '0;
    dv        = '0;
    lock      = 1'b0;
    out_ready = 1'b0;
    #12 rst_n = 1'b1;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_ack", 32'(ack), 0);

    // Round-robin with all four requesting.
    for (int i = 0; i < 4; i++) dv[i] = 32'(i + 1);
    req       = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_data", out_data, 32'((i % 4) + 1));
      chk("rr_sel", 32'(sel), 32'(i % 4));
      chk("rr_ack", 32'(ack), 32'(1 << (i % 4)));
    end

    // Backpressure: everything holds, no ack.
    out_ready = 1'b0;
    req       = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_data", out_data, 1);
      chk("bp_sel", 32'(sel), 0);
      chk("bp_grant", 32'(grant), 1);
      chk("bp_ack", 32'(ack), 0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_resume_sel", 32'(sel), 1);
    chk("bp_resume_data", out_data, 2);

    // Wrap 3 -> 0 and the ack mask.
    req = 4'b1000;
    tick();
    chk("wrap_sel3", 32'(sel), 3);
    req = 4'b1001;
    tick();
    chk("wrap_sel0", 32'(sel), 0);
    chk("wrap_data", out_data, 1);
    tick();
    chk("mask_sel", 32'(sel), 3);
    chk("mask_ack", 32'(ack), 32'h8);

    // Drain.
    req = 4'b0000;
    tick();
    chk("drain_valid", 32'(out_valid), 0);
    chk("drain_sel", 32'(sel), 3);
    chk("drain_grant", 32'(grant), 32'h8);
    chk("drain_ack", 32'(ack), 0);

    // Asynchronous reset while a word is held.
    out_ready = 1'b0;
    req       = 4'b0100;
    dv[2]     = 32'hDEADBEEF;
    tick();
    chk("pre_rst_data", out_data, 32'hDEADBEEF);
    req = 4'b0000;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_data", out_data, 0);
    chk("arst_sel", 32'(sel), 0);
    chk("arst_grant", 32'(grant), 0);
    chk("arst_ack", 32'(ack), 0);
    #2 rst_n = 1'b1;
    req       = 4'b0100;
    out_ready = 1'b1;
    tick();
    chk("post_rst_data", out_data, 32'hDEADBEEF);
    chk("post_rst_sel", 32'(sel), 2);
    chk("post_rst_grant", 32'(grant), 32'h4);
    chk("post_rst_ack", 32'(ack), 32'h4);

`ifdef MUX4_ARB_LOCK_EN
    req = 4'b0010;
    tick();
    chk("lock_pre_sel", 32'(sel), 1);
    lock = 1'b1;
    req  = 4'b0011;
    tick();
    chk("lock_sel_a", 32'(sel), 1);
    chk("lock_ack_a", 32'(ack), 32'h2);
    tick();
    chk("lock_sel_b", 32'(sel), 1);
    lock = 1'b0;
    tick();
    chk("unlock_sel", 32'(sel), 0);
`endif

    req = 4'b0000;
    tick();
    tick();
    chk("end_valid", 32'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
